// File: rtl/mac_seq_ctrl_if.sv
// mac_seq_ctrl_if: job, pair-stream and result ports of the single-lane MAC
// sequencer, bundled so the SRAM-reader side and writeback side see one bus.
//   start/len/busy              : job control (len sampled with start)
//   in_valid/in_ready/a/b       : activation (unsigned) / weight (signed) stream
//   out_valid/out_ready/out     : final psum result
//   beat_cnt                    : pairs accepted so far in the current job
// slave  = controller side, master = requester/consumer side.
interface mac_seq_ctrl_if #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 8
);
    logic               start;
    logic [cnt_bw-1:0]  len;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic [bw-1:0]      a;
    logic [bw-1:0]      b;
    logic               out_valid;
    logic               out_ready;
    logic [psum_bw-1:0] out;
    logic [cnt_bw-1:0]  beat_cnt;

    modport slave (
        input  start, len, in_valid, a, b, out_ready,
        output busy, in_ready, out_valid, out, beat_cnt
    );

    modport master (
        output start, len, in_valid, a, b, out_ready,
        input  busy, in_ready, out_valid, out, beat_cnt
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: single-lane dot-product sequencer around one MAC
// (unsigned a x signed b + psum). Accepts a job of len pairs, accumulates
// them, and presents the final sum until downstream takes it.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset, priority over everything
//   bus   : mac_seq_ctrl_if slave modport (job, pair stream, result)
module mac_seq_ctrl #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int cnt_bw  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mac_seq_ctrl_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t             state, state_nxt;
    logic [psum_bw-1:0] acc;
    logic [psum_bw-1:0] out_q;
    logic [cnt_bw-1:0]  beat_cnt_q;
    logic [cnt_bw-1:0]  len_q;
    logic               in_ready_c;
    logic               out_valid_c;

    // a zero-extended, b sign-extended; the product always fits in 2*bw
    // signed bits, so a 2*bw-bit multiply is exact.
    logic        [2*bw-1:0]    a_ext, b_ext;
    logic signed [2*bw-1:0]    prod;
    logic signed [psum_bw-1:0] prod_ext;
    logic        [psum_bw-1:0] sum;
    logic                      beat;
    logic                      last_beat;

    assign a_ext    = {{bw{1'b0}}, bus.a};
    assign b_ext    = {{bw{bus.b[bw-1]}}, bus.b};
    assign prod     = signed'(a_ext * b_ext);
    assign prod_ext = psum_bw'(prod);
    assign sum      = acc + prod_ext;   // wraps modulo 2^psum_bw

    assign beat      = bus.in_valid && (state == ACC);
    assign last_beat = (beat_cnt_q == len_q - cnt_bw'(1));

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    state_nxt = (bus.len != '0) ? ACC : DONE;
            end
            ACC: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && last_beat)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            out_q      <= '0;
            beat_cnt_q <= '0;
            len_q      <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc        <= '0;
                        beat_cnt_q <= '0;
                        len_q      <= bus.len;
                        // zero-length job skips ACC, so its result is set here
                        if (bus.len == '0)
                            out_q <= '0;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc        <= sum;
                        beat_cnt_q <= beat_cnt_q + cnt_bw'(1);
                        // capture the sum including the final pair
                        if (last_beat)
                            out_q <= sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out       = out_q;
    assign bus.beat_cnt  = beat_cnt_q;
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed bench for mac_seq_ctrl. A 16-bit instance covers
// the main job flows; an 8-bit-psum instance covers accumulator wrap-around.
// Expected sums come from an integer model pushed to a scoreboard queue at
// job start and popped when the result is presented.
module tb_mac_seq_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.bw(4), .psum_bw(16), .cnt_bw(8)) ifm ();
    mac_seq_ctrl_if #(.bw(4), .psum_bw(8),  .cnt_bw(8)) ifw ();

    mac_seq_ctrl #(.bw(4), .psum_bw(16), .cnt_bw(8)) dut_m (
        .clk(clk), .reset(reset), .bus(ifm.slave));
    mac_seq_ctrl #(.bw(4), .psum_bw(8), .cnt_bw(8)) dut_w (
        .clk(clk), .reset(reset), .bus(ifw.slave));

    int n_cmp = 0;
    int n_err = 0;
    int av[$];
    int bv[$];
    logic [15:0] exp_q[$];
    logic [7:0]  exp_wq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one job on the 16-bit instance using av/bv. gap: idle cycles
    // between beats; hold: cycles out_ready stays low in DONE; restart_at:
    // beat index at which a spurious start(len=1) is driven (-1 = none).
    task automatic run_job(input int gap, input int hold, input int restart_at);
        int n;
        int s;
        logic [15:0] e;
        n = av.size();
        s = 0;
        for (int i = 0; i < n; i++) s += av[i] * bv[i];
        exp_q.push_back(16'(s));

        @(negedge clk);
        ifm.start = 1'b1;
        ifm.len   = 8'(n);
        @(negedge clk);
        ifm.start = 1'b0;
        ifm.len   = '0;
        chk("busy_after_start", ifm.busy, 1);
        chk("in_ready_after_start", ifm.in_ready, (n > 0));

        for (int i = 0; i < n; i++) begin
            ifm.in_valid = 1'b1;
            ifm.a = 4'(av[i]);
            ifm.b = 4'(bv[i]);
            if (i == restart_at) begin
                ifm.start = 1'b1;
                ifm.len   = 8'd1;
            end
            chk("beat_cnt_before_beat", ifm.beat_cnt, i);
            chk("no_early_out_valid", ifm.out_valid, 0);
            @(negedge clk);
            ifm.start    = 1'b0;
            ifm.len      = '0;
            ifm.in_valid = 1'b0;
            if (i < n - 1) begin
                for (int g = 0; g < gap; g++) begin
                    ifm.a = 4'($urandom);
                    ifm.b = 4'($urandom);
                    chk("gap_in_ready", ifm.in_ready, 1);
                    @(negedge clk);
                    chk("gap_beat_cnt_hold", ifm.beat_cnt, i + 1);
                end
            end
        end

        e = exp_q.pop_front();
        chk("done_out_valid", ifm.out_valid, 1);
        chk("done_in_ready", ifm.in_ready, 0);
        chk("done_beat_cnt", ifm.beat_cnt, n);
        chk("done_out", ifm.out, e);
        for (int h = 0; h < hold; h++) begin
            ifm.in_valid = 1'b1;
            ifm.a = 4'($urandom);
            ifm.b = 4'($urandom);
            @(negedge clk);
            chk("hold_out_valid", ifm.out_valid, 1);
            chk("hold_out_stable", ifm.out, e);
            chk("hold_in_ready", ifm.in_ready, 0);
        end
        ifm.in_valid  = 1'b0;
        ifm.out_ready = 1'b1;
        @(negedge clk);
        ifm.out_ready = 1'b0;
        chk("idle_busy", ifm.busy, 0);
        chk("idle_out_valid", ifm.out_valid, 0);
        chk("idle_out_kept", ifm.out, e);
    endtask

    // Back-to-back job on the 8-bit-psum instance; result checked mod 256.
    task automatic run_job_w();
        int n;
        int s;
        logic [7:0] e;
        n = av.size();
        s = 0;
        for (int i = 0; i < n; i++) s += av[i] * bv[i];
        exp_wq.push_back(8'(s));
        @(negedge clk);
        ifw.start = 1'b1;
        ifw.len   = 8'(n);
        @(negedge clk);
        ifw.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            ifw.in_valid = 1'b1;
            ifw.a = 4'(av[i]);
            ifw.b = 4'(bv[i]);
            @(negedge clk);
        end
        ifw.in_valid = 1'b0;
        e = exp_wq.pop_front();
        chk("wrap_out_valid", ifw.out_valid, 1);
        chk("wrap_out", ifw.out, e);
        ifw.out_ready = 1'b1;
        @(negedge clk);
        ifw.out_ready = 1'b0;
        chk("wrap_idle", ifw.busy, 0);
    endtask

    initial begin
        ifm.start = 0; ifm.len = 0; ifm.in_valid = 0; ifm.a = 0; ifm.b = 0; ifm.out_ready = 0;
        ifw.start = 0; ifw.len = 0; ifw.in_valid = 0; ifw.a = 0; ifw.b = 0; ifw.out_ready = 0;

        // reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", ifm.busy, 0);
        chk("rst_in_ready", ifm.in_ready, 0);
        chk("rst_out_valid", ifm.out_valid, 0);
        chk("rst_out", ifm.out, 0);
        chk("rst_beat_cnt", ifm.beat_cnt, 0);
        chk("rst_w_out", ifw.out, 0);

        // basic dot product: 6 - 120 + 7 = -107
        av = '{3, 15, 7}; bv = '{2, -8, 1};
        run_job(0, 0, -1);

        // gaps between beats and downstream backpressure
        run_job(2, 5, -1);

        // zero-length job
        av = {}; bv = {};
        run_job(0, 0, -1);

        // spurious start mid-job is ignored
        av = '{1, 2, 3, 4}; bv = '{5, -6, 7, -1};
        run_job(1, 1, 2);

        // wrap-around in the 8-bit accumulator
        av = '{15, 15, 15}; bv = '{7, 7, 7};
        run_job_w();
        av = '{15, 15, 15}; bv = '{-8, -8, -8};
        run_job_w();

        // reset mid-job after 2 of 5 beats
        @(negedge clk);
        ifm.start = 1'b1; ifm.len = 8'd5;
        @(negedge clk);
        ifm.start = 1'b0; ifm.len = '0;
        for (int i = 0; i < 2; i++) begin
            ifm.in_valid = 1'b1; ifm.a = 4'd9; ifm.b = 4'd3;
            @(negedge clk);
        end
        chk("midjob_beat_cnt", ifm.beat_cnt, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ifm.in_valid = 1'b0;
        chk("abort_busy", ifm.busy, 0);
        chk("abort_in_ready", ifm.in_ready, 0);
        chk("abort_out", ifm.out, 0);
        chk("abort_beat_cnt", ifm.beat_cnt, 0);
        av = '{1}; bv = '{1};
        run_job(0, 0, -1);

        chk("scoreboard_empty", exp_q.size() + exp_wq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
